wide_add_seq: RTL and testbench

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

---
 rtl/wide_add_seq.sv | 110 +++++++++++
 tb/tb_wide_add_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: one 32-bit word per clock through a single shared adder.
// Optional signed-overflow output enabled by defining WIDE_ADD_SEQ_OVF_EN.
module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [32*WORDS-1:0]   a,
  input  logic [32*WORDS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [32*WORDS-1:0]   sum,
  output logic                  cout
`ifdef WIDE_ADD_SEQ_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int W  = 32 * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [31:0]     a_w;
  logic [31:0]     b_w;
  logic [32:0]     add_res;

  logic accept;
  assign accept = (state == IDLE) && start;

  // NOTE: operand latches are pure datapath, written only on an accepted start and
  // never read before that, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Shared 32-bit adder; the word counter selects the operand slice.
  always_comb begin
    a_w     = a_q[cnt*32 +: 32];
    b_w     = b_q[cnt*32 +: 32];
    add_res = {1'b0, a_w} + {1'b0, b_w} + {32'd0, carry};
  end

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef WIDE_ADD_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
            carry <= cin;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          sum[cnt*32 +: 32] <= add_res[31:0];
          carry             <= add_res[32];
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= add_res[32];
`ifdef WIDE_ADD_SEQ_OVF_EN
            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            ovf   <= add_res[32] ^ (a_w[31] ^ b_w[31] ^ add_res[31]);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: directed vector table, random operations
// against a plain-arithmetic reference, and hand-written multi-cycle sequences.
module tb_wide_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           cin;
  logic           busy;
  logic           done;
  logic [W-1:0]   sum;
  logic           cout;
`ifdef WIDE_ADD_SEQ_OVF_EN
  logic           ovf;
`endif

  int checks = 0;
  int errors = 0;

  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef WIDE_ADD_SEQ_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: full-width addition as one arithmetic expression.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] r;
    for (int i = 0; i < WORDS; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Caller must be at a falling edge with the DUT idle.
  task automatic apply_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input string nm);
    int n;
    int nbusy;
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = rand_wide(); b = rand_wide(); cin = ~tc;
    n = 1;
    nbusy = 0;
    while (done !== 1'b1 && n <= 3 * WORDS + 4) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      n++;
    end
    check({nm, ".latency"}, n, WORDS + 1);
    check({nm, ".busy_cycles"}, nbusy, WORDS);
    check({nm, ".busy_at_done"}, busy, 1'b0);
    check({nm, ".sum"}, sum, es);
    check({nm, ".cout"}, cout, ec);
`ifdef WIDE_ADD_SEQ_OVF_EN
    check({nm, ".ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("unexpected x in expected ovf for %s", nm);
`endif
    @(negedge clk);
    check({nm, ".done_pulse"}, done, 1'b0);
    check({nm, ".sum_hold"}, sum, es);
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  vec_t vecs[6];

  logic [W-1:0] ops_a[32];
  logic [W-1:0] ops_b[32];
  logic         ops_c[32];
  bit           exp_done[32];
  int           acc_of[32];

  initial begin
    logic [W-1:0] ta, tb_v;
    logic         tc;
    logic [W:0]   r;
    logic [W-1:0] got_s;
    logic         got_c;
    int           ndone, first, nbusy;

    // Directed vectors with hand-derived expected results.
    vecs[0] = '{'1, W'(1), 1'b0, '0, 1'b1, 1'b0};
    vecs[1] = '{128'h0000_0001_FFFF_FFFF_0000_0000_FFFF_FFFF, '0, 1'b1,
                128'h0000_0001_FFFF_FFFF_0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[2] = '{{1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1};
    vecs[3] = '{'0, '0, 1'b0, '0, 1'b0, 1'b0};
    vecs[4] = '{'1, '1, 1'b1, '1, 1'b1, 1'b0};
    vecs[5] = '{128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0000,
                128'h0000_0001_0000_0001_0000_0001_0000_0001, 1'b0,
                128'h0000_0000_0000_0002_0000_0000_0000_0001, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.sum", sum, '0);
    check("reset.cout", cout, 1'b0);
`ifdef WIDE_ADD_SEQ_OVF_EN
    check("reset.ovf", ovf, 1'b0);
`endif

    // Start on the very first edge after reset release.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      apply_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec, vecs[i].eo,
               $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      ta = rand_wide(); tb_v = rand_wide(); tc = 1'($urandom);
      r = ref_add(ta, tb_v, tc);
      apply_op(ta, tb_v, tc, r[W-1:0], r[W], ref_ovf(ta, tb_v, r[W-1:0]),
               $sformatf("rand%0d", i));
    end

    // Start re-pulsed during RUN with the input buses already changed.
    ta = rand_wide(); tb_v = rand_wide(); tc = 1'($urandom);
    r = ref_add(ta, tb_v, tc);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge clk);
    ndone = 0; first = -1; got_s = '0; got_c = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin
          first = n; got_s = sum; got_c = cout;
        end
      end
      if (n == 1) begin
        start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc;
      end
      if (n == 2) start = 1'b1;
      if (n == 3) start = 1'b0;
    end
    check("busy_start.done_count", ndone, 1);
    check("busy_start.latency", first, WORDS + 1);
    check("busy_start.sum", got_s, r[W-1:0]);
    check("busy_start.cout", got_c, r[W]);

    // Reset asserted in the middle of RUN.
    a = rand_wide(); b = rand_wide(); cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset.sum", sum, '0);
    check("midreset.busy", busy, 1'b0);
    check("midreset.done", done, 1'b0);
    ndone = 0; nbusy = 0;
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      if (busy === 1'b1) nbusy++;
    end
    check("midreset.no_done", ndone, 0);
    check("midreset.idle_after", nbusy, 0);
    ta = rand_wide(); tb_v = rand_wide(); tc = 1'($urandom);
    r = ref_add(ta, tb_v, tc);
    apply_op(ta, tb_v, tc, r[W-1:0], r[W], ref_ovf(ta, tb_v, r[W-1:0]), "after_reset");

    // Start held high for 20 cycles: one operation per IDLE visit.
    for (int e = 0; e < 32; e++) begin
      exp_done[e] = 1'b0;
      acc_of[e]   = 0;
    end
    for (int acc = 0; acc < 20; acc += WORDS + 2) begin
      exp_done[acc + WORDS] = 1'b1;
      acc_of[acc + WORDS]   = acc;
    end
    for (int e = 0; e < 28; e++) begin
      ops_a[e] = rand_wide(); ops_b[e] = rand_wide(); ops_c[e] = 1'($urandom);
      a = ops_a[e]; b = ops_b[e]; cin = ops_c[e]; start = (e < 20);
      @(negedge clk);
      check($sformatf("b2b.done@%0d", e), done, exp_done[e]);
      if (exp_done[e]) begin
        r = ref_add(ops_a[acc_of[e]], ops_b[acc_of[e]], ops_c[acc_of[e]]);
        check($sformatf("b2b.sum@%0d", e), sum, r[W-1:0]);
        check($sformatf("b2b.cout@%0d", e), cout, r[W]);
      end
    end
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
